// File: rtl/onoff_pkg.sv
// Shared types and constants for the on/off FSM bank.
// State encoding and mode values are fixed because downstream tooling decodes them.
package onoff_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        ON_PEND  = 2'd1,
        ON       = 2'd2,
        OFF_PEND = 2'd3
    } onoff_state_e;

    localparam logic MODE_SETCLR = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

endpackage

// File: rtl/onoff_chan.sv
// One on/off channel: Moore FSM with programmable turn-on/turn-off delays,
// request decode for set/clear and toggle modes, and a global kill.
module onoff_chan
    import onoff_pkg::*;
#(
    parameter int DLY_W     = 8,
    parameter int ON_DELAY  = 3,
    parameter int OFF_DELAY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic mode,
    input  logic kill,
    input  logic a,
    input  logic b,
    output logic out,
    output logic busy
);

    // Counter load values: a pending state lasts DELAY cycles, so it
    // starts at DELAY-1 and leaves when it has counted down to zero.
    localparam logic [DLY_W-1:0] ON_LOAD  = (ON_DELAY  == 0) ? '0 : DLY_W'(ON_DELAY  - 1);
    localparam logic [DLY_W-1:0] OFF_LOAD = (OFF_DELAY == 0) ? '0 : DLY_W'(OFF_DELAY - 1);

    onoff_state_e     state_reg, state_next;
    logic [DLY_W-1:0] cnt_reg, cnt_next;
    logic             a_prev_reg;

    logic a_rise;
    logic start;
    logic stop;

    always_comb begin
        a_rise = a & ~a_prev_reg;
        if (mode == MODE_SETCLR) begin
            start = a;
            stop  = b;
        end else begin
            start = a_rise & ~b;
            stop  = a_rise | b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= OFF;
            cnt_reg    <= '0;
            a_prev_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            a_prev_reg <= a;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (kill) begin
            state_next = OFF;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                OFF: begin
                    if (start) begin
                        if (ON_DELAY == 0) begin
                            state_next = ON;
                        end else begin
                            state_next = ON_PEND;
                            cnt_next   = ON_LOAD;
                        end
                    end
                end
                ON_PEND: begin
                    // A cancel on the expiry edge still wins.
                    if (stop) begin
                        state_next = OFF;
                        cnt_next   = '0;
                    end else if (cnt_reg == '0) begin
                        state_next = ON;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                ON: begin
                    if (stop) begin
                        if (OFF_DELAY == 0) begin
                            state_next = OFF;
                        end else begin
                            state_next = OFF_PEND;
                            cnt_next   = OFF_LOAD;
                        end
                    end
                end
                OFF_PEND: begin
                    if (start) begin
                        state_next = ON;
                        cnt_next   = '0;
                    end else if (cnt_reg == '0) begin
                        state_next = OFF;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_next = OFF;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs depend on state only, so reset clears them without waiting for clk.
    assign out  = (state_reg == ON)      || (state_reg == OFF_PEND);
    assign busy = (state_reg == ON_PEND) || (state_reg == OFF_PEND);

endmodule

// File: rtl/onoff_fsm_bank.sv
// Bank of NUM_CH independent on/off channels sharing mode and kill.
module onoff_fsm_bank
    import onoff_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DLY_W     = 8,
    parameter int ON_DELAY  = 3,
    parameter int OFF_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              kill,
    input  logic [NUM_CH-1:0] a,
    input  logic [NUM_CH-1:0] b,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] busy
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            onoff_chan #(
                .DLY_W     (DLY_W),
                .ON_DELAY  (ON_DELAY),
                .OFF_DELAY (OFF_DELAY)
            ) u_chan (
                .clk   (clk),
                .reset (reset),
                .mode  (mode),
                .kill  (kill),
                .a     (a[gi]),
                .b     (b[gi]),
                .out   (out[gi]),
                .busy  (busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_onoff_fsm_bank.sv
// Directed bench for onoff_fsm_bank with ON_DELAY=3, OFF_DELAY=2, NUM_CH=4.
module tb_onoff_fsm_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       kill;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic [3:0] busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       mode;
        logic       kill;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] out;
        logic [3:0] busy;
    } vec_t;

    vec_t vecs[$];

    onoff_fsm_bank #(
        .NUM_CH    (4),
        .DLY_W     (8),
        .ON_DELAY  (3),
        .OFF_DELAY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .kill  (kill),
        .a     (a),
        .b     (b),
        .out   (out),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, got, exp);
        end
    endtask

    task automatic add(input logic m, input logic k, input logic [3:0] va, input logic [3:0] vb,
                       input logic [3:0] vo, input logic [3:0] vbz);
        vec_t v;
        v.mode = m; v.kill = k; v.a = va; v.b = vb; v.out = vo; v.busy = vbz;
        vecs.push_back(v);
    endtask

    // One clocked transaction: apply inputs, take the edge, compare both outputs.
    task automatic apply(input string name, input logic m, input logic k, input logic [3:0] va,
                         input logic [3:0] vb, input logic [3:0] vo, input logic [3:0] vbz);
        mode = m; kill = k; a = va; b = vb;
        step();
        $display("%s mode=%0d kill=%0d a=%b b=%b -> out=%b busy=%b", name, m, k, va, vb, out, busy);
        check({name, ".out"}, out, vo);
        check({name, ".busy"}, busy, vbz);
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; kill = 1'b0; a = '0; b = '0;

        // Mode 0 set/clear, cancellation and cancel-over-expiry vectors.
        add(0,0,4'b0011,4'b0000,4'b0000,4'b0011); // ch0, ch1 start
        add(0,0,4'b0000,4'b0010,4'b0000,4'b0001); // ch1 cancelled
        add(0,0,4'b0000,4'b0000,4'b0000,4'b0001);
        add(0,0,4'b0000,4'b0000,4'b0001,4'b0000); // ch0 on at t+3
        add(0,0,4'b0000,4'b0001,4'b0001,4'b0001); // clear ch0
        add(0,0,4'b0000,4'b0000,4'b0001,4'b0001);
        add(0,0,4'b0000,4'b0000,4'b0000,4'b0000); // off at u+2
        add(0,0,4'b0001,4'b0000,4'b0000,4'b0001);
        add(0,0,4'b0000,4'b0000,4'b0000,4'b0001);
        add(0,0,4'b0000,4'b0000,4'b0000,4'b0001);
        add(0,0,4'b0000,4'b0000,4'b0001,4'b0000);
        add(0,0,4'b0000,4'b0001,4'b0001,4'b0001); // b from ON
        add(0,0,4'b0001,4'b0000,4'b0001,4'b0000); // a cancels off
        add(0,0,4'b0000,4'b0000,4'b0001,4'b0000);
        add(0,0,4'b0000,4'b0001,4'b0001,4'b0001);
        add(0,0,4'b0000,4'b0000,4'b0001,4'b0001); // cnt now 0
        add(0,0,4'b0001,4'b0000,4'b0001,4'b0000); // cancel beats expiry
        add(0,0,4'b0000,4'b0001,4'b0001,4'b0001);
        add(0,0,4'b0000,4'b0000,4'b0001,4'b0001);
        add(0,0,4'b0000,4'b0000,4'b0000,4'b0000);
        add(0,0,4'b0100,4'b0000,4'b0000,4'b0100); // ch2 start
        add(0,0,4'b0000,4'b0000,4'b0000,4'b0100);
        add(0,0,4'b0000,4'b0000,4'b0000,4'b0100); // cnt now 0
        add(0,0,4'b0000,4'b0100,4'b0000,4'b0000); // stop beats expiry

        // Reset state and asynchronous reset in the middle of ON_PEND.
        #12;
        check("reset.out", out, 4'b0000);
        check("reset.busy", busy, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        apply("rst_pre", 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        $display("async reset -> out=%b busy=%b", out, busy);
        check("async_reset.out", out, 4'b0000);
        check("async_reset.busy", busy, 4'b0000);
        a = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            apply($sformatf("rst_post%0d", i), 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i].mode, vecs[i].kill, vecs[i].a, vecs[i].b,
                  vecs[i].out, vecs[i].busy);

        // Toggle mode: holding a high gives exactly one toggle.
        for (int k = 0; k < 10; k++)
            apply($sformatf("tog_hold%0d", k), 1, 0, 4'b0100, 4'b0000,
                  (k >= 3) ? 4'b0100 : 4'b0000, (k < 3) ? 4'b0100 : 4'b0000);
        apply("tog_low",   1, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        apply("tog_rise2", 1, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        apply("tog_off1",  1, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        apply("tog_off2",  1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // b held with a rising edge: must not start.
        apply("tog_bprio", 1, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        apply("tog_bprio2",1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Kill with ch0/ch1 ON and ch2/ch3 pending; simultaneous a ignored.
        apply("kill_s0", 0, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        apply("kill_s1", 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0011);
        apply("kill_s2", 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0011);
        apply("kill_s3", 0, 0, 4'b0100, 4'b0000, 4'b0011, 4'b0100);
        apply("kill_s4", 0, 0, 4'b1000, 4'b0000, 4'b0011, 4'b1100);
        apply("kill",    0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        apply("kill_p0", 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        apply("kill_p1", 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
